inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
- Upstream feeder of the instruction-fetch stage.
- Receives a program byte stream from the UART receiver and assembles big-endian 32-bit instruction words.
- Writes each word into instruction memory at consecutive addresses from 0.
- Frames each load with single-cycle input_start / input_end pulses; fetch uses these to drop and restore inst_enable.

Parameters:
- INST_MEM_WIDTH, 2: address width of instruction memory; depth = 2**INST_MEM_WIDTH words.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- load_req  input  1  request to begin a program load; sampled only in IDLE.
- rx_data  input  8  received byte.
- rx_valid  input  1  rx_data valid this cycle (one byte per asserted cycle).
- input_start  output  1  one-cycle pulse marking load start.
- input_end  output  1  one-cycle pulse marking load completion.
- loading  output  1  high while a load is in progress.
- we  output  1  instruction memory write enable, one cycle per word.
- waddr  output  INST_MEM_WIDTH  write address.
- wdata  output  32  write data.
- overflow  output  1  sticky; program longer than memory depth.

Behaviour:
- Reset:
  - input_start = input_end = loading = we = overflow = 0; waddr = 0; wdata = 0.
  - State IDLE; byte counter, word count and word index all cleared.
  - Reset mid-load aborts the load immediately; no input_end is emitted.
- States: IDLE, HDR, BODY, FINISH.
- IDLE:
  - rx_valid ignored.
  - On load_req = 1 → HDR. In the following cycle input_start = 1 (one cycle) and loading = 1.
  - overflow, byte counter, word count and word index clear in the same cycle.
- HDR:
  - Accepts 4 bytes, MSB first, forming a 32-bit word count N: N = {N[23:0], rx_data} per accepted byte.
  - After the 4th byte: N == 0 → FINISH; else → BODY.
- BODY:
  - Accepts bytes MSB first into a 32-bit shift register. A 2-bit byte counter wraps 3 → 0.
  - On acceptance of the 4th byte of a word, in the next cycle:
    - we = 1, wdata = assembled word, waddr = word index[INST_MEM_WIDTH-1:0], provided word index < 2**INST_MEM_WIDTH.
    - Otherwise we stays 0 and overflow is set (sticky).
  - Word index (32-bit) increments on every completed word, written or discarded.
  - When the completed word is word N-1 → FINISH.
- FINISH (one cycle):
  - Entered from HDR: input_end = 1 in the cycle after the 4th header byte.
  - Entered from BODY: input_end = 1 in the cycle immediately after the final we cycle, or after the final discarded-word cycle.
  - Then → IDLE. loading falls together with input_end deassertion, i.e. loading is high from the input_start cycle through the input_end cycle inclusive.
- Other rules:
  - load_req while not IDLE is ignored.
  - rx_valid in FINISH is ignored; the byte is dropped.
  - Back-to-back rx_valid (every cycle) is fully supported; the write of word k may overlap byte accepts of word k+1.
  - Gaps between bytes are unbounded; there is no timeout.
  - load_req and rx_valid in the same IDLE cycle: load starts; that byte is not consumed.
  - we, waddr and wdata are registered outputs. waddr and wdata hold their last value when we = 0.
  - overflow holds after FINISH until the next load start or reset.

Test Plan:
- Basic load: reset, then load_req. Stream 00 00 00 02, 11 22 33 44, AA BB CC DD.
  → input_start 1 cycle after load_req.
  → we @waddr 0 with 11223344, then we @waddr 1 with AABBCCDD.
  → input_end the cycle after the 2nd write; loading spans start..end; overflow = 0.
- Empty program: header 00 00 00 00 → no we; input_end the cycle after the 4th byte; back to IDLE.
- Overflow (W=2): N = 6, words 1..6. → we for words 1..4 at addresses 0..3 only; overflow set on word 5; input_end after word 6; overflow still 1 in IDLE.
- Gapped and back-to-back bytes: N = 1, bytes 01 02 03 04 with 0–5 idle cycles between them. → single write of 01020304 @0. Repeat with rx_valid every cycle → identical result.
- Ignored inputs:
  - rx_valid pulses in IDLE → no state change.
  - load_req during BODY → no second input_start; load completes normally.
- Reset mid-load: assert reset after 2 of 3 words are written. → all outputs 0 next cycle, no input_end. New load_req restarts at waddr 0 with overflow cleared.

Source files
------------

// File: rtl/inst_loader.sv
// inst_loader: assembles a UART byte stream into big-endian 32-bit words and writes them to instruction memory
// Ports: CLK/reset (sync, active-high); load_req starts a load from IDLE; rx_data/rx_valid byte input;
// input_start/input_end one-cycle frame pulses; loading high start..end inclusive;
// we/waddr/wdata registered memory write; overflow sticky when the program exceeds memory depth.
module inst_loader #(
  parameter int INST_MEM_WIDTH = 2
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      load_req,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic                      input_start,
  output logic                      input_end,
  output logic                      loading,
  output logic                      we,
  output logic [INST_MEM_WIDTH-1:0] waddr,
  output logic [31:0]               wdata,
  output logic                      overflow
);
  typedef enum logic [1:0] {IDLE, HDR, BODY, FINISH} state_t;
  state_t      r_state;
  logic [1:0]  r_bcnt;
  logic [31:0] r_cnt, r_idx, r_sh;
  logic        r_done;
  logic [31:0] w_hdr, w_word;
  logic        w_fits;
  assign w_hdr  = {r_cnt[23:0], rx_data};
  assign w_word = {r_sh[23:0], rx_data};
  assign w_fits = (r_idx >> INST_MEM_WIDTH) == 32'd0;
  // r_done holds BODY one extra cycle after the last word so input_end trails the final write/discard cycle
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bcnt      <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_sh        <= '0;
      r_done      <= 1'b0;
      input_start <= 1'b0;
      input_end   <= 1'b0;
      loading     <= 1'b0;
      we          <= 1'b0;
      waddr       <= '0;
      wdata       <= '0;
      overflow    <= 1'b0;
    end else begin
      input_start <= 1'b0;
      input_end   <= 1'b0;
      we          <= 1'b0;
      case (r_state)
        IDLE: if (load_req) begin
          r_state     <= HDR;
          input_start <= 1'b1;
          loading     <= 1'b1;
          overflow    <= 1'b0;
          r_bcnt      <= '0;
          r_cnt       <= '0;
          r_idx       <= '0;
          r_done      <= 1'b0;
        end
        HDR: if (rx_valid) begin
          r_cnt  <= w_hdr;
          r_bcnt <= r_bcnt + 2'd1;
          if (r_bcnt == 2'd3) begin
            r_state   <= (w_hdr == 32'd0) ? FINISH : BODY;
            input_end <= (w_hdr == 32'd0);
          end
        end
        BODY: if (r_done) begin
          r_state   <= FINISH;
          input_end <= 1'b1;
          r_done    <= 1'b0;
        end else if (rx_valid) begin
          r_sh   <= w_word;
          r_bcnt <= r_bcnt + 2'd1;
          if (r_bcnt == 2'd3) begin
            r_idx  <= r_idx + 32'd1;
            r_done <= (r_idx == r_cnt - 32'd1);
            if (w_fits) begin
              we    <= 1'b1;
              waddr <= r_idx[INST_MEM_WIDTH-1:0];
              wdata <= w_word;
            end else begin
              overflow <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          loading <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: directed self-checking bench for inst_loader
module tb_inst_loader;
  logic        CLK = 1'b0, reset = 1'b0, load_req = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        input_start, input_end, loading, we, overflow;
  logic [1:0]  waddr;
  logic [31:0] wdata;
  int n_chk = 0, n_pass = 0;
  int cyc = 0, req_cyc = 0, byte_cyc = 0;
  int n_start = 0, n_end = 0, n_load = 0, start_cyc = 0, end_cyc = 0, last_we = 0;
  logic [31:0] wa_q[$], wd_q[$];

  inst_loader #(.INST_MEM_WIDTH(2)) dut (
    .CLK(CLK), .reset(reset), .load_req(load_req), .rx_data(rx_data), .rx_valid(rx_valid),
    .input_start(input_start), .input_end(input_end), .loading(loading), .we(we),
    .waddr(waddr), .wdata(wdata), .overflow(overflow)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (we) begin
      wa_q.push_back({30'd0, waddr});
      wd_q.push_back(wdata);
      last_we = cyc;
    end
    if (input_start) begin n_start++; start_cyc = cyc; end
    if (input_end) begin n_end++; end_cyc = cyc; end
    if (loading) n_load++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] qa(input int i);
    return (i < wa_q.size()) ? wa_q[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] qd(input int i);
    return (i < wd_q.size()) ? wd_q[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic clr();
    wa_q.delete(); wd_q.delete();
    n_start = 0; n_end = 0; n_load = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_data = b; rx_valid = 1'b1; byte_cyc = cyc;
    tick(1);
    rx_valid = 1'b0;
    tick(gap);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send(w[31:24], gap); send(w[23:16], gap); send(w[15:8], gap); send(w[7:0], gap);
  endtask

  task automatic start_load();
    load_req = 1'b1; req_cyc = cyc;
    tick(1);
    load_req = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int k = 0;
    while (n_end == 0 && k < 60) begin tick(1); k++; end
    chk(tag, n_end, 1);
    tick(2);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    chk("reset_outs", {input_start, input_end, loading, we, overflow, waddr, wdata}, 39'd0);
    reset = 1'b0;
  endtask

  initial begin
    tick(1);
    do_reset();
    // basic two-word load
    clr();
    start_load();
    send_word(32'h0000_0002, 0);
    send_word(32'h1122_3344, 0);
    send_word(32'hAABB_CCDD, 0);
    wait_end("t1_end");
    chk("t1_start_cnt", n_start, 1);
    chk("t1_start_lat", start_cyc - req_cyc, 1);
    chk("t1_we_cnt", wa_q.size(), 2);
    chk("t1_addr0", qa(0), 0);
    chk("t1_data0", qd(0), 32'h1122_3344);
    chk("t1_addr1", qa(1), 1);
    chk("t1_data1", qd(1), 32'hAABB_CCDD);
    chk("t1_end_after_we", end_cyc - last_we, 1);
    chk("t1_end_lat", end_cyc - byte_cyc, 2);
    chk("t1_load_span", n_load, end_cyc - start_cyc + 1);
    chk("t1_loading_off", loading, 0);
    chk("t1_ovf", overflow, 0);
    chk("t1_hold", {30'd0, waddr}, 1);
    // empty program
    clr();
    start_load();
    send_word(32'h0, 0);
    wait_end("t2_end");
    chk("t2_we_cnt", wa_q.size(), 0);
    chk("t2_end_lat", end_cyc - byte_cyc, 1);
    chk("t2_loading_off", loading, 0);
    // overflow: six words into a four-word memory
    clr();
    start_load();
    send_word(32'h6, 0);
    for (int i = 1; i <= 6; i++) send_word(i, 0);
    wait_end("t3_end");
    chk("t3_we_cnt", wa_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t3_addr", qa(i), i);
      chk("t3_data", qd(i), i + 1);
    end
    chk("t3_end_lat", end_cyc - byte_cyc, 2);
    chk("t3_ovf_idle", overflow, 1);
    chk("t3_loading_off", loading, 0);
    // gapped bytes; overflow must clear on start
    clr();
    start_load();
    chk("t4_ovf_clr", overflow, 0);
    send_word(32'h1, 1);
    send(8'h01, 3); send(8'h02, 0); send(8'h03, 5); send(8'h04, 2);
    wait_end("t4_end");
    chk("t4_we_cnt", wa_q.size(), 1);
    chk("t4_addr", qa(0), 0);
    chk("t4_data", qd(0), 32'h0102_0304);
    // back-to-back bytes
    clr();
    start_load();
    send_word(32'h1, 0);
    send_word(32'h0102_0304, 0);
    wait_end("t4b_end");
    chk("t4b_we_cnt", wa_q.size(), 1);
    chk("t4b_data", qd(0), 32'h0102_0304);
    // rx_valid in IDLE ignored; byte coinciding with load_req not consumed
    clr();
    send(8'h55, 0); send(8'h66, 2);
    chk("t5_idle_loading", loading, 0);
    chk("t5_idle_start", n_start, 0);
    rx_data = 8'hFF; rx_valid = 1'b1;
    start_load();
    rx_valid = 1'b0;
    send_word(32'h1, 0);
    send(8'hDE, 0); send(8'hAD, 0);
    load_req = 1'b1;
    send(8'hBE, 0);
    load_req = 1'b0;
    send(8'hEF, 0);
    wait_end("t5_end");
    chk("t5_start_cnt", n_start, 1);
    chk("t5_we_cnt", wa_q.size(), 1);
    chk("t5_data", qd(0), 32'hDEAD_BEEF);
    chk("t5_idle", loading, 0);
    // reset mid-load after two of three words
    clr();
    start_load();
    send_word(32'h3, 0);
    send_word(32'hCAFE_0001, 0);
    send_word(32'hCAFE_0002, 0);
    tick(2);
    chk("t6_we_cnt", wa_q.size(), 2);
    do_reset();
    tick(10);
    chk("t6_no_end", n_end, 0);
    clr();
    start_load();
    send_word(32'h1, 0);
    send_word(32'h7777_8888, 0);
    wait_end("t6_end");
    chk("t6_addr", qa(0), 0);
    chk("t6_data", qd(0), 32'h7777_8888);
    chk("t6_ovf", overflow, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
